// File: rtl/data_mem_pkg.sv
// Shared constants and FSM state encoding for the data memory unit.
package data_mem_pkg;

    localparam int unsigned BYTE_OFF_W  = 2;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_DEPTH   = 1024;
    localparam int unsigned DEF_LATENCY = 2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/data_mem_if.sv
// Request/done handshake bundle between the memory stage and the data memory unit.
interface data_mem_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  Req;
    logic                  WriteEnable;
    logic [DATA_W/8-1:0]   ByteEn;
    logic [31:0]           Address;
    logic [DATA_W-1:0]     WriteData;
    logic                  Ready;
    logic                  Done;
    logic [DATA_W-1:0]     MemData;
    logic                  AddrError;

    modport master (
        output Req, WriteEnable, ByteEn, Address, WriteData,
        input  Ready, Done, MemData, AddrError
    );

    modport slave (
        input  Req, WriteEnable, ByteEn, Address, WriteData,
        output Ready, Done, MemData, AddrError
    );
endinterface

// File: rtl/data_mem_array.sv
// Word storage with per-lane synchronous writes and a registered read port.
// The read register only changes on rd_en, so it doubles as the load-result holder.
module data_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        lane_en,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       rd_en,
    input  logic                       rd_zero,
    output logic [DATA_W-1:0]          rdata
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < int'(NB); i++) begin
            if (we && lane_en[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[addr];
        end
    end
endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory: request/done handshake, programmable latency, address checks.
// Define DATA_MEM_BYTE_WRITE_EN to honour ByteEn on stores; otherwise stores write full words.
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic       Clk,
    input  logic       Reset,
    data_mem_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                accept_c, access_c;
    logic                ready_q, done_q, err_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       lane_en_c;
    logic                addr_err_c;

`ifdef DATA_MEM_BYTE_WRITE_EN
    logic [NB-1:0]       be_q;
    assign lane_en_c = be_q;
`else
    assign lane_en_c = '1;
`endif

    assign addr_err_c = (|addr_q[BYTE_OFF_W-1:0]) || (|addr_q[31:AW+BYTE_OFF_W]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next state, counter and access strobes.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        accept_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    accept_c = 1'b1;
                    cnt_n    = CNT_W'(LATENCY - 1);
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    access_c = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output flags follow the next state; request fields are latched only on acceptance.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DATA_MEM_BYTE_WRITE_EN
            be_q    <= '0;
`endif
        end else begin
            ready_q <= (state_n == S_IDLE);
            done_q  <= (state_n == S_DONE);
            if (access_c) begin
                err_q <= addr_err_c;
            end
            if (accept_c) begin
                we_q    <= bus.WriteEnable;
                addr_q  <= bus.Address;
                wdata_q <= bus.WriteData;
`ifdef DATA_MEM_BYTE_WRITE_EN
                be_q    <= bus.ByteEn;
`endif
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .Clk     (Clk),
        .Reset   (Reset),
        .addr    (addr_q[AW+BYTE_OFF_W-1:BYTE_OFF_W]),
        .we      (access_c && we_q && !addr_err_c),
        .lane_en (lane_en_c),
        .wdata   (wdata_q),
        .rd_en   (access_c && !we_q),
        .rd_zero (addr_err_c),
        .rdata   (bus.MemData)
    );

    assign bus.Ready     = ready_q;
    assign bus.Done      = done_q;
    assign bus.AddrError = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (DATA_W=32, DEPTH=1024, LATENCY=2).
module tb_data_mem_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    data_mem_if #(.DATA_W(32)) bus ();

    data_mem_unit #(
        .DATA_W  (32),
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; returns cycles from accept to Done (as seen on falling edges) and the results.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge Clk);
        bus.Req         = 1'b1;
        bus.WriteEnable = we;
        bus.ByteEn      = be;
        bus.Address     = addr;
        bus.WriteData   = wd;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            lat++;
            if (bus.Done) break;
        end
        rd = bus.MemData;
        er = bus.AddrError;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          ndone;
        int          dpos[3];
        logic [31:0] lane_exp;

        Reset           = 1'b1;
        bus.Req         = 1'b0;
        bus.WriteEnable = 1'b0;
        bus.ByteEn      = '0;
        bus.Address     = '0;
        bus.WriteData   = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Reset state, then idle with Req low
        chk("rst_ready", bus.Ready, 1);
        chk("rst_done", bus.Done, 0);
        chk("rst_memdata", bus.MemData, 0);
        chk("rst_err", bus.AddrError, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("idle_ready", bus.Ready, 1);
            chk("idle_done", bus.Done, 0);
        end

        // Store then load
        xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("st_lat", lat, 3);
        chk("st_err", er, 0);
        chk("st_memdata_kept", rd, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        chk("ld_lat", lat, 3);
        chk("ld_data", rd, 32'hDEADBEEF);
        chk("ld_err", er, 0);

        // Single-lane store over the previous word
`ifdef DATA_MEM_BYTE_WRITE_EN
        lane_exp = 32'hDEADBEAA;
`else
        lane_exp = 32'h000000AA;
`endif
        xact(1'b1, 4'b0001, 32'h10, 32'h000000AA, rd, er, lat);
        chk("lane_st_err", er, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        chk("lane_ld_data", rd, lane_exp);

        // Misaligned load
        xact(1'b0, 4'hF, 32'h13, 32'h0, rd, er, lat);
        chk("mis_err", er, 1);
        chk("mis_data", rd, 0);

        // Out-of-range store must not alias onto word 0
        xact(1'b1, 4'hF, 32'h0, 32'h11223344, rd, er, lat);
        xact(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
        chk("w0_data", rd, 32'h11223344);
        xact(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
        chk("oor_err", er, 1);
        chk("oor_memdata_kept", rd, 32'h11223344);
        xact(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
        chk("oor_w0_unchanged", rd, 32'h11223344);
        chk("oor_w0_err", er, 0);

        // Reset during WAIT of a store
        xact(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, rd, er, lat);
        @(negedge Clk);
        bus.Req         = 1'b1;
        bus.WriteEnable = 1'b1;
        bus.ByteEn      = 4'hF;
        bus.Address     = 32'h20;
        bus.WriteData   = 32'h12345678;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_ready", bus.Ready, 1);
        chk("abort_done", bus.Done, 0);
        chk("abort_memdata", bus.MemData, 0);
        @(negedge Clk);
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (bus.Done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        xact(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lat);
        chk("abort_old_data", rd, 32'hCAFEF00D);

        // Req held high: three loads, Done every LATENCY+2 cycles
        @(negedge Clk);
        bus.Req         = 1'b1;
        bus.WriteEnable = 1'b0;
        bus.ByteEn      = 4'hF;
        bus.Address     = 32'h10;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge Clk);
            if (bus.Done) begin
                if (ndone < 3) dpos[ndone] = e;
                ndone++;
            end
        end
        bus.Req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.Done) ndone++;
        end
        chk("b2b_count", ndone, 3);
        chk("b2b_first", dpos[0], 2);
        chk("b2b_gap1", dpos[1] - dpos[0], 4);
        chk("b2b_gap2", dpos[2] - dpos[1], 4);
        chk("b2b_data", bus.MemData, lane_exp);
        chk("b2b_ready", bus.Ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
